// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared operation codes and sizing helper for the register file
package register_file_pkg;

    typedef enum logic [1:0] {
        MODE_WRITE  = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    // An address needs at least one bit, even for a single-entry file.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/module_sync_edge.sv
// rtl/module_sync_edge.sv - two-flop synchroniser with rising-edge single-cycle pulse
//
// Ports:
//   clk_i   : system clock
//   arst_i  : asynchronous active-high reset
//   async_i : asynchronous level input (e.g. a button)
//   pulse_o : one-cycle pulse after each synchronised rising edge of async_i
module module_sync_edge (
    input  logic clk_i,
    input  logic arst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // r_s1/r_s2 resolve metastability; r_s3 remembers the previous
    // synchronised level so a held input produces only one pulse.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign pulse_o = r_s2 & ~r_s3;

endmodule

// File: rtl/module_register_file.sv
// rtl/module_register_file.sv - button-driven register file with write/shift/rotate/clear and registered read port
//
// Ports:
//   clk_i      : system clock
//   arst_i     : asynchronous active-high reset
//   en_i       : asynchronous operation request; one operation per rising edge
//   mode_i     : operation select (write, shift, rotate, clear), sampled at commit
//   addr_i     : write address for the write operation
//   data_i     : write/shift data, sampled at commit
//   rd_addr_i  : read address
//   data_o     : registered read data
//   rd_valid_o : registered valid flag of the addressed entry
//   count_o    : number of valid entries
//   full_o     : all entries valid
module module_register_file
    import register_file_pkg::*;
#(
    parameter  int DATA_WIDTH = 10,
    parameter  int DEPTH      = 4,
    localparam int ADDR_WIDTH = addr_width(DEPTH),
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  en_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rd_valid_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_entry [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rd_valid;

    logic                  w_pulse;
    mode_e                 w_mode;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [CNT_WIDTH-1:0]  w_count;

    module_sync_edge u_sync_edge (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .async_i (en_i),
        .pulse_o (w_pulse)
    );

    assign w_mode        = mode_e'(mode_i);
    // DEPTH need not be a power of two, so addresses can name missing entries.
    assign w_wr_in_range = ({1'b0, addr_i} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, rd_addr_i} < DEPTH_EXT);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_valid <= '0;
        end else if (w_pulse) begin
            case (w_mode)
                MODE_WRITE: begin
                    if (w_wr_in_range) begin
                        r_entry[addr_i] <= data_i;
                        r_valid[addr_i] <= 1'b1;
                    end
                end
                MODE_SHIFT: begin
                    // The last entry falls off the end.
                    r_entry[0] <= data_i;
                    r_valid[0] <= 1'b1;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_entry[i] <= r_entry[i-1];
                        r_valid[i] <= r_valid[i-1];
                    end
                end
                MODE_ROTATE: begin
                    // With DEPTH = 1 this reassigns entry 0 to itself.
                    r_entry[0] <= r_entry[DEPTH-1];
                    r_valid[0] <= r_valid[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        r_entry[i] <= r_entry[i-1];
                        r_valid[i] <= r_valid[i-1];
                    end
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_entry[i] <= '0;
                    end
                    r_valid <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Read port samples storage before any same-edge commit lands.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_in_range) begin
            r_data     <= r_entry[rd_addr_i];
            r_rd_valid <= r_valid[rd_addr_i];
        end else begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_WIDTH'(r_valid[i]);
        end
    end

    assign data_o     = r_data;
    assign rd_valid_o = r_rd_valid;
    assign count_o    = w_count;
    assign full_o     = (w_count == DEPTH_CNT);

endmodule

// File: tb/tb_module_register_file.sv
// tb/tb_module_register_file.sv - directed scoreboard bench for module_register_file (DEPTH 4 and DEPTH 3)
module tb_module_register_file;

    logic       clk;
    logic       arst;
    logic       en_a;
    logic       en_b;
    logic [1:0] mode;
    logic [1:0] addr;
    logic [9:0] data;
    logic [1:0] rd_addr;

    logic [9:0] a_data;
    logic       a_vld;
    logic [2:0] a_cnt;
    logic       a_full;
    logic [9:0] b_data;
    logic       b_vld;
    logic [1:0] b_cnt;
    logic       b_full;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [9:0] d;
        logic       v;
        bit         b;
    } exp_t;

    exp_t sb_q[$];

    module_register_file #(.DATA_WIDTH(10), .DEPTH(4)) dut_a (
        .clk_i      (clk),
        .arst_i     (arst),
        .en_i       (en_a),
        .mode_i     (mode),
        .addr_i     (addr),
        .data_i     (data),
        .rd_addr_i  (rd_addr),
        .data_o     (a_data),
        .rd_valid_o (a_vld),
        .count_o    (a_cnt),
        .full_o     (a_full)
    );

    module_register_file #(.DATA_WIDTH(10), .DEPTH(3)) dut_b (
        .clk_i      (clk),
        .arst_i     (arst),
        .en_i       (en_b),
        .mode_i     (mode),
        .addr_i     (addr),
        .data_i     (data),
        .rd_addr_i  (rd_addr),
        .data_o     (b_data),
        .rd_valid_o (b_vld),
        .count_o    (b_cnt),
        .full_o     (b_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input bit sel_b, input logic [1:0] m, input logic [1:0] a, input logic [9:0] d);
        @(negedge clk);
        mode = m;
        addr = a;
        data = d;
        if (sel_b) en_b = 1'b1;
        else       en_a = 1'b1;
        repeat (3) @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_read(input bit sel_b, input logic [1:0] a, input logic [9:0] d, input logic v, input string tag);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.v   = v;
        e.b   = sel_b;
        sb_q.push_back(e);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, "_data"}, e.b ? 16'(b_data) : 16'(a_data), 16'(e.d));
        check({e.tag, "_vld"},  e.b ? 16'(b_vld)  : 16'(a_vld),  16'(e.v));
    endtask

    initial begin
        arst    = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        mode    = 2'b00;
        addr    = 2'd0;
        data    = 10'd0;
        rd_addr = 2'd0;
        #1 arst = 1'b1;
        #2;
        check("rst_data", 16'(a_data), 16'h0);
        check("rst_vld",  16'(a_vld),  16'h0);
        check("rst_cnt",  16'(a_cnt),  16'h0);
        check("rst_full", 16'(a_full), 16'h0);
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // Write with en held high: single commit at edge 2, read one edge later
        rd_addr = 2'd2;
        mode    = 2'b00;
        addr    = 2'd2;
        data    = 10'h155;
        en_a    = 1'b1;
        @(posedge clk); #1;
        check("wr_e0_cnt", 16'(a_cnt), 16'd0);
        @(posedge clk); #1;
        check("wr_e1_cnt", 16'(a_cnt), 16'd0);
        @(posedge clk); #1;
        check("wr_e2_cnt",  16'(a_cnt),  16'd1);
        check("wr_e2_data", 16'(a_data), 16'h0);
        @(posedge clk); #1;
        check("wr_e3_data", 16'(a_data), 16'h155);
        check("wr_e3_vld",  16'(a_vld),  16'd1);
        @(negedge clk);
        data = 10'h0AA;
        repeat (7) @(posedge clk);
        #1;
        check("wr_hold_data", 16'(a_data), 16'h155);
        check("wr_hold_cnt",  16'(a_cnt),  16'd1);
        @(negedge clk);
        en_a = 1'b0;
        repeat (4) @(negedge clk);

        // Shift 1..5 from an empty file
        press(1'b0, 2'b11, 2'd0, 10'd0);
        check("clr0_cnt", 16'(a_cnt), 16'd0);
        for (int i = 1; i <= 5; i++) begin
            press(1'b0, 2'b01, 2'd0, 10'(i));
            check($sformatf("sh%0d_cnt", i),  16'(a_cnt),  16'((i < 4) ? i : 4));
            check($sformatf("sh%0d_full", i), 16'(a_full), 16'((i >= 4) ? 1 : 0));
        end
        check_read(1'b0, 2'd0, 10'd5, 1'b1, "sh_r0");
        check_read(1'b0, 2'd1, 10'd4, 1'b1, "sh_r1");
        check_read(1'b0, 2'd2, 10'd3, 1'b1, "sh_r2");
        check_read(1'b0, 2'd3, 10'd2, 1'b1, "sh_r3");

        // Rotate once, data_i ignored
        press(1'b0, 2'b10, 2'd0, 10'h3FF);
        check("rot_cnt", 16'(a_cnt), 16'd4);
        check_read(1'b0, 2'd0, 10'd2, 1'b1, "rot_r0");
        check_read(1'b0, 2'd1, 10'd5, 1'b1, "rot_r1");
        check_read(1'b0, 2'd2, 10'd4, 1'b1, "rot_r2");
        check_read(1'b0, 2'd3, 10'd3, 1'b1, "rot_r3");

        // Clear, then a single write
        press(1'b0, 2'b11, 2'd0, 10'h3FF);
        check("clr_cnt",  16'(a_cnt),  16'd0);
        check("clr_full", 16'(a_full), 16'd0);
        for (int i = 0; i < 4; i++) begin
            check_read(1'b0, 2'(i), 10'd0, 1'b0, $sformatf("clr_r%0d", i));
        end
        press(1'b0, 2'b00, 2'd0, 10'h123);
        check("clr_wr_cnt", 16'(a_cnt), 16'd1);

        // DEPTH 3: out-of-range write and read
        press(1'b1, 2'b00, 2'd3, 10'h2AA);
        check("oor_cnt",  16'(b_cnt),  16'd0);
        check("oor_full", 16'(b_full), 16'd0);
        check_read(1'b1, 2'd3, 10'd0, 1'b0, "oor_r3");
        press(1'b1, 2'b00, 2'd2, 10'h111);
        check("b_wr2_cnt", 16'(b_cnt), 16'd1);
        check_read(1'b1, 2'd2, 10'h111, 1'b1, "b_r2");
        check_read(1'b1, 2'd3, 10'd0, 1'b0, "b_r3_again");
        press(1'b1, 2'b00, 2'd0, 10'h001);
        press(1'b1, 2'b00, 2'd1, 10'h002);
        check("b_full_cnt", 16'(b_cnt),  16'd3);
        check("b_full",     16'(b_full), 16'd1);

        // Reset mid-synchronisation with entries loaded
        check_read(1'b0, 2'd0, 10'h123, 1'b1, "pre_rst_r0");
        @(negedge clk);
        mode = 2'b00;
        addr = 2'd1;
        data = 10'h077;
        en_a = 1'b1;
        @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check("mid_rst_data", 16'(a_data), 16'h0);
        check("mid_rst_vld",  16'(a_vld),  16'h0);
        check("mid_rst_cnt",  16'(a_cnt),  16'h0);
        check("mid_rst_full", 16'(a_full), 16'h0);
        check("mid_rst_bcnt", 16'(b_cnt),  16'h0);
        @(negedge clk);
        en_a = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_cnt", 16'(a_cnt), 16'd0);
        check_read(1'b0, 2'd1, 10'd0, 1'b0, "post_rst_r1");
        check_read(1'b0, 2'd0, 10'd0, 1'b0, "post_rst_r0");

        check("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
